// File: rtl/demux32_1to3_reg_if.sv
// Bus bundle for demux32_1to3_reg: source beat with select, three destination
// ports with per-port ready, and invalid-select error status.
interface demux32_1to3_reg_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     in;
  logic                 sel1;
  logic                 sel2;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out1;
  logic [WIDTH-1:0]     out2;
  logic [WIDTH-1:0]     out3;
  logic [2:0]           out_valid;
  logic [2:0]           out_ready;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_flag;

  modport master (
    output in, sel1, sel2, in_valid, out_ready,
    input  in_ready, out1, out2, out3, out_valid, err_count, err_flag
  );

  modport slave (
    input  in, sel1, sel2, in_valid, out_ready,
    output in_ready, out1, out2, out3, out_valid, err_count, err_flag
  );
endinterface

// File: rtl/demux32_1to3_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshake, steered by {sel1,sel2}.
// Define DEMUX_ERR_CNT_EN to build the saturating invalid-select counter and sticky flag.
//
// state | meaning
// IDLE  | no beat held, out_valid == 000
// HOLD  | one beat held in exactly one outk, out_valid one-hot
module demux32_1to3_reg #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic              clk,
  input logic              reset,
  demux32_1to3_reg_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       valid_q, valid_nxt;
  logic [2:0]       load;
  logic [WIDTH-1:0] out1_q, out2_q, out3_q;
  logic [1:0]       code;
  logic             in_ready;
  logic             accept;
  logic             deliver;
  logic             sel_ok;

  assign code = {bus.sel1, bus.sel2};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 3'b000;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
    end
  end

  // A new valid beat overrides the clearing of a beat delivered on the same edge.
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    load      = 3'b000;
    deliver   = 1'b0;
    in_ready  = 1'b1;
    sel_ok    = (code != 2'b11);
    if (state == HOLD) begin
      deliver  = |(valid_q & bus.out_ready);
      in_ready = deliver;
    end
    accept = bus.in_valid & in_ready;
    if (deliver)
      valid_nxt = 3'b000;
    if (accept && sel_ok) begin
      load      = 3'b001 << code;
      valid_nxt = load;
    end
    state_nxt = (valid_nxt != 3'b000) ? HOLD : IDLE;
  end

  // Data registers keep their last value after delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
    end else begin
      if (load[0]) out1_q <= bus.in;
      if (load[1]) out2_q <= bus.in;
      if (load[2]) out3_q <= bus.in;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.out3      = out3_q;

`ifdef DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 err_flag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (accept && !sel_ok) begin
      if (err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;
      err_flag_q <= 1'b1;
    end
  end

  assign bus.err_count = err_cnt_q;
  assign bus.err_flag  = err_flag_q;
`else
  assign bus.err_count = '0;
  assign bus.err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_demux32_1to3_reg.sv
// Self-checking bench for demux32_1to3_reg: directed scenarios plus random traffic
// compared against a slot-level reference model.
module tb_demux32_1to3_reg;

  logic clk;
  logic reset;

  demux32_1to3_reg_if #(.WIDTH(32), .ERR_CNT_W(8)) bus ();

  demux32_1to3_reg #(.WIDTH(32), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which destination holds an undelivered beat (-1 = none),
  // last word written to each destination, and error tracking.
  int          held;
  logic [31:0] mdata [3];
  int          merr;
  bit          mflag;

`ifdef DEMUX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    logic [2:0] exp_valid;
    exp_valid = (held < 0) ? 3'b000 : 3'(1 << held);
    chk({where, " out1"},      bus.out1,             mdata[0]);
    chk({where, " out2"},      bus.out2,             mdata[1]);
    chk({where, " out3"},      bus.out3,             mdata[2]);
    chk({where, " out_valid"}, 32'(bus.out_valid),   32'(exp_valid));
    chk({where, " err_count"}, 32'(bus.err_count),   ERR_EN ? 32'(merr) : 32'd0);
    chk({where, " err_flag"},  32'(bus.err_flag),    ERR_EN ? 32'(mflag) : 32'd0);
  endtask

  // Called at a negedge; applies inputs, checks in_ready, clocks once, checks outputs.
  task automatic step(input string where, input logic [31:0] d, input logic [1:0] s,
                      input logic v, input logic [2:0] r);
    bit exp_rdy;
    bus.in       = d;
    bus.sel1     = s[1];
    bus.sel2     = s[0];
    bus.in_valid = v;
    bus.out_ready = r;
    #1;
    exp_rdy = (held < 0) || r[held];
    chk({where, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (held >= 0 && r[held]) held = -1;
    if (v && exp_rdy) begin
      if (s != 2'b11) begin
        mdata[s] = d;
        held     = int'(s);
      end else begin
        if (merr < 255) merr++;
        mflag = 1'b1;
      end
    end
    #1;
    check_outputs(where);
    @(negedge clk);
  endtask

  // Reset with a competing beat on the bus to show reset has priority.
  task automatic do_reset(input string where);
    bus.in        = 32'hFFFF_FFFF;
    bus.sel1      = 1'b0;
    bus.sel2      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 3'b000;
    reset         = 1'b1;
    @(posedge clk);
    held  = -1;
    mdata = '{32'd0, 32'd0, 32'd0};
    merr  = 0;
    mflag = 1'b0;
    #1;
    reset = 1'b0;
    check_outputs(where);
    chk({where, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  s;
    logic        v;
    logic [2:0]  r;

    reset         = 1'b1;
    bus.in        = '0;
    bus.sel1      = 1'b0;
    bus.sel2      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b000;
    held  = -1;
    mdata = '{32'd0, 32'd0, 32'd0};
    merr  = 0;
    mflag = 1'b0;
    @(negedge clk);

    do_reset("reset");

    for (int k = 0; k < 3; k++) begin
      step("single", 32'hDEAD_BEEF, 2'(k), 1'b1, 3'b111);
      step("single_dlv", 32'h0, 2'b00, 1'b0, 3'b111);
    end

    step("stall_acc", 32'h1234_5678, 2'b01, 1'b1, 3'b111);
    for (int i = 0; i < 5; i++)
      step("stall", 32'hA5A5_0000 + 32'(i), 2'b00, 1'b1, (i == 2) ? 3'b101 : 3'b000);
    step("stall_rel", 32'h0, 2'b00, 1'b0, 3'b010);
    step("stall_idle", 32'h0, 2'b00, 1'b0, 3'b000);

    step("b2b", 32'd1, 2'b00, 1'b1, 3'b111);
    step("b2b", 32'd2, 2'b01, 1'b1, 3'b111);
    step("b2b", 32'd3, 2'b10, 1'b1, 3'b111);
    step("b2b", 32'd4, 2'b00, 1'b1, 3'b111);
    step("b2b_end", 32'd0, 2'b00, 1'b0, 3'b111);

    step("inv_hold", 32'hCAFE_0001, 2'b10, 1'b1, 3'b000);
    step("inv_dlv", 32'hCAFE_0002, 2'b11, 1'b1, 3'b100);
    for (int i = 0; i < 300; i++)
      step("invalid", $urandom, 2'b11, 1'b1, 3'(i));

    for (int i = 0; i < 250; i++) begin
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      r = 3'($urandom_range(0, 7));
      step("random", d, s, v, r);
    end

    step("rst_hold", 32'h7777_3333, 2'b10, 1'b1, 3'b000);
    step("rst_stall", 32'h0, 2'b00, 1'b0, 3'b000);
    do_reset("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
